// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers a byte from a two-digit multiplexed seven-segment bus.
// Samples {dig_sel, seg_in} through a synchroniser, accepts a pattern once it has
// been stable for STABLE_CYCLES cycles, decodes the glyph to a nibble and pairs
// the low and high digits into byte_out.
// Optional build macro SEG7_SCAN_CHANGE_ONLY_EN: byte_valid only pulses when the
// completed pair differs from the byte currently shown on byte_out.
module seg7_scan_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
   input  logic       dig_sel,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       pattern_err,
   output logic       lo_seen,
   output logic       hi_seen
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_ACCEPT = CW'(STABLE_CYCLES - 1);

   typedef enum logic {SETTLE, HOLD} state_t;

   logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
   logic [7:0]    prev_q, prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   state_t        state_q, state_d;
   logic [3:0]    lo_q, lo_d, hi_q, hi_d;
   logic          lo_seen_q, lo_seen_d, hi_seen_q, hi_seen_d;
   logic [7:0]    byte_q, byte_d;
   logic          byte_valid_q, byte_valid_d;
   logic          pattern_err_q, pattern_err_d;

   logic [7:0] v;
   logic [3:0] nib;
   logic       glyph_ok, changed, accept, blank, sel, lo_next, hi_next, pair;

   assign v = sync_q[SYNC_STAGES-1];

   // glyph lookup: segment pattern of the synchronised value to hex nibble
   always_comb begin
      nib      = 4'h0;
      glyph_ok = 1'b1;
      case (v[6:0])
         7'h3F: nib = 4'h0;
         7'h06: nib = 4'h1;
         7'h5B: nib = 4'h2;
         7'h4F: nib = 4'h3;
         7'h66: nib = 4'h4;
         7'h6D: nib = 4'h5;
         7'h7D: nib = 4'h6;
         7'h07: nib = 4'h7;
         7'h7F: nib = 4'h8;
         7'h67: nib = 4'h9;
         7'h77: nib = 4'hA;
         7'h7C: nib = 4'hB;
         7'h39: nib = 4'hC;
         7'h5E: nib = 4'hD;
         7'h79: nib = 4'hE;
         7'h71: nib = 4'hF;
         default: glyph_ok = 1'b0;
      endcase
   end

   // settle tracking, accept decision, slot update and pair completion
   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], {dig_sel, seg_in}};
      changed   = v != prev_q;
      prev_d    = v;
      cnt_d     = changed ? '0 : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
      accept    = state_q == SETTLE && !changed && cnt_d == CNT_ACCEPT;
      state_d   = changed ? SETTLE : (accept ? HOLD : state_q);
      sel       = v[7];
      blank     = v[6:0] == 7'h00;
      lo_d      = accept && glyph_ok && !sel ? nib : lo_q;
      hi_d      = accept && glyph_ok && sel ? nib : hi_q;
      lo_next   = accept && !sel && !blank ? glyph_ok : lo_seen_q;
      hi_next   = accept && sel && !blank ? glyph_ok : hi_seen_q;
      pair      = accept && glyph_ok && lo_next && hi_next;
      byte_d    = pair ? {hi_d, lo_d} : byte_q;
      lo_seen_d = lo_next && !pair;
      hi_seen_d = hi_next && !pair;
`ifdef SEG7_SCAN_CHANGE_ONLY_EN
      byte_valid_d = pair && ({hi_d, lo_d} != byte_q);
`else
      byte_valid_d = pair;
`endif
      pattern_err_d = accept && !blank && !glyph_ok;
   end

   // all state registers; reset clears partial captures and output pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q        <= '0;
         prev_q        <= '0;
         cnt_q         <= '0;
         state_q       <= SETTLE;
         lo_q          <= '0;
         hi_q          <= '0;
         lo_seen_q     <= 1'b0;
         hi_seen_q     <= 1'b0;
         byte_q        <= '0;
         byte_valid_q  <= 1'b0;
         pattern_err_q <= 1'b0;
      end else begin
         sync_q        <= sync_d;
         prev_q        <= prev_d;
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         lo_q          <= lo_d;
         hi_q          <= hi_d;
         lo_seen_q     <= lo_seen_d;
         hi_seen_q     <= hi_seen_d;
         byte_q        <= byte_d;
         byte_valid_q  <= byte_valid_d;
         pattern_err_q <= pattern_err_d;
      end
   end

   assign byte_out    = byte_q;
   assign byte_valid  = byte_valid_q;
   assign pattern_err = pattern_err_q;
   assign lo_seen     = lo_seen_q;
   assign hi_seen     = hi_seen_q;
endmodule
